// File: rtl/stack_seq_pkg.sv
// Shared definitions for the stack sequencer.
// Provides the cmd_op encodings, the sequencer state enum and the int_count
// step codes that the interrupt-entry sequence reports.
package stack_seq_pkg;

  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_CALL = 2'b01,
    CMD_RET  = 2'b10,
    CMD_RTI  = 2'b11
  } cmd_op_e;

  typedef enum logic [3:0] {
    StIdle,
    StIntHi,
    StIntLo,
    StIntFl,
    StCallHi,
    StCallLo,
    StRetLo,
    StRetHi,
    StRtiFl,
    StRtiLo,
    StRtiHi,
    StRedirect
  } state_e;

  localparam logic [1:0] INT_STEP_IDLE = 2'b00;
  localparam logic [1:0] INT_STEP_HI   = 2'b01;
  localparam logic [1:0] INT_STEP_LO   = 2'b10;
  localparam logic [1:0] INT_STEP_FL   = 2'b11;

endpackage

// File: rtl/stack_sequencer.sv
// Stack sequencer: multi-cycle controller driving the memory stage's stack
// port for interrupt entry, CALL, RET and RTI.
// Inputs : clk, rst_n (async, active low), int_req, cmd_valid/cmd_op/cmd_target,
//          cur_pc and flags_in (state to save), mem_rdata (same-cycle pop data).
// Outputs: stall (front-end freeze), push/pop/wdata (stack port), int_count and
//          int_active (interrupt-entry progress), pc_load/pc_next (redirect),
//          flags_load/flags_out (RTI flag restore).
module stack_sequencer
  import stack_seq_pkg::*;
#(
  parameter logic [31:0] INT_VECTOR = 32'h0000_0000,
  parameter int unsigned PC_W       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            int_req,
  input  logic            cmd_valid,
  input  logic [1:0]      cmd_op,
  input  logic [PC_W-1:0] cmd_target,
  input  logic [PC_W-1:0] cur_pc,
  input  logic [2:0]      flags_in,
  input  logic [15:0]     mem_rdata,
  output logic            stall,
  output logic            push,
  output logic            pop,
  output logic [15:0]     wdata,
  output logic [1:0]      int_count,
  output logic            int_active,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_next,
  output logic            flags_load,
  output logic [2:0]      flags_out
);

  // The PC is pushed as exactly two 16-bit halves.
  if (PC_W != 32) begin : gen_pc_w_check
    $error("stack_sequencer: PC_W must be 32");
  end

  state_e          state_q, state_d;
  logic            int_pend_q, int_pend_d;
  logic [PC_W-1:0] spc_q, spc_d;
  logic [2:0]      sflg_q, sflg_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic [2:0]      rflg_q, rflg_d;
  logic            is_rti_q, is_rti_d;
  logic            int_any;

  // A request arriving in the acceptance cycle itself still wins priority.
  assign int_any = int_pend_q | int_req;

  always_comb begin
    state_d    = state_q;
    int_pend_d = int_pend_q | int_req;
    spc_d      = spc_q;
    sflg_d     = sflg_q;
    tgt_d      = tgt_q;
    rflg_d     = rflg_q;
    is_rti_d   = is_rti_q;
    stall      = (state_q != StIdle);
    push       = 1'b0;
    pop        = 1'b0;
    wdata      = 16'h0000;
    int_count  = INT_STEP_IDLE;
    int_active = 1'b0;
    pc_load    = 1'b0;
    pc_next    = '0;
    flags_load = 1'b0;
    flags_out  = 3'b000;

    unique case (state_q)
      StIdle: begin
        if (int_any) begin
          stall      = 1'b1;
          int_pend_d = 1'b0;
          spc_d      = cur_pc;
          sflg_d     = flags_in;
          tgt_d      = INT_VECTOR;
          is_rti_d   = 1'b0;
          state_d    = StIntHi;
        end else if (cmd_valid && (cmd_op != CMD_NONE)) begin
          stall    = 1'b1;
          spc_d    = cur_pc;
          sflg_d   = flags_in;
          tgt_d    = cmd_target;
          is_rti_d = (cmd_op == CMD_RTI);
          unique case (cmd_op)
            CMD_CALL: state_d = StCallHi;
            CMD_RET:  state_d = StRetLo;
            CMD_RTI:  state_d = StRtiFl;
            default:  state_d = StIdle;
          endcase
        end
      end
      StIntHi: begin
        push       = 1'b1;
        wdata      = spc_q[31:16];
        int_count  = INT_STEP_HI;
        int_active = 1'b1;
        state_d    = StIntLo;
      end
      StIntLo: begin
        push       = 1'b1;
        wdata      = spc_q[15:0];
        int_count  = INT_STEP_LO;
        int_active = 1'b1;
        state_d    = StIntFl;
      end
      StIntFl: begin
        push       = 1'b1;
        wdata      = {13'b0, sflg_q};
        int_count  = INT_STEP_FL;
        int_active = 1'b1;
        state_d    = StRedirect;
      end
      StCallHi: begin
        push    = 1'b1;
        wdata   = spc_q[31:16];
        state_d = StCallLo;
      end
      StCallLo: begin
        push    = 1'b1;
        wdata   = spc_q[15:0];
        state_d = StRedirect;
      end
      StRetLo: begin
        pop     = 1'b1;
        tgt_d   = {tgt_q[31:16], mem_rdata};
        state_d = StRetHi;
      end
      StRetHi: begin
        pop     = 1'b1;
        tgt_d   = {mem_rdata, tgt_q[15:0]};
        state_d = StRedirect;
      end
      StRtiFl: begin
        pop     = 1'b1;
        rflg_d  = mem_rdata[2:0];
        state_d = StRtiLo;
      end
      StRtiLo: begin
        pop     = 1'b1;
        tgt_d   = {tgt_q[31:16], mem_rdata};
        state_d = StRtiHi;
      end
      StRtiHi: begin
        pop     = 1'b1;
        tgt_d   = {mem_rdata, tgt_q[15:0]};
        state_d = StRedirect;
      end
      StRedirect: begin
        pc_load = 1'b1;
        pc_next = tgt_q;
        if (is_rti_q) begin
          flags_load = 1'b1;
          flags_out  = rflg_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      int_pend_q <= 1'b0;
      spc_q      <= '0;
      sflg_q     <= 3'b000;
      tgt_q      <= '0;
      rflg_q     <= 3'b000;
      is_rti_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      int_pend_q <= int_pend_d;
      spc_q      <= spc_d;
      sflg_q     <= sflg_d;
      tgt_q      <= tgt_d;
      rflg_q     <= rflg_d;
      is_rti_q   <= is_rti_d;
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer. The bench plays the memory stage:
// a queue holds the stack, pushes append to it and pops read its top word.
// Expected targets and flags come from the stack contents and the op rules.
module tb_stack_sequencer;
  import stack_seq_pkg::*;

  localparam logic [31:0] IntVec = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        int_req = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_target = '0;
  logic [31:0] cur_pc = '0;
  logic [2:0]  flags_in = '0;
  logic [15:0] mem_rdata = '0;
  logic        stall, push, pop, int_active, pc_load, flags_load;
  logic [15:0] wdata;
  logic [1:0]  int_count;
  logic [31:0] pc_next;
  logic [2:0]  flags_out;

  stack_sequencer #(
    .INT_VECTOR(IntVec),
    .PC_W      (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .int_req   (int_req),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_target(cmd_target),
    .cur_pc    (cur_pc),
    .flags_in  (flags_in),
    .mem_rdata (mem_rdata),
    .stall     (stall),
    .push      (push),
    .pop       (pop),
    .wdata     (wdata),
    .int_count (int_count),
    .int_active(int_active),
    .pc_load   (pc_load),
    .pc_next   (pc_next),
    .flags_load(flags_load),
    .flags_out (flags_out)
  );

  always #5 clk = ~clk;

  logic [58:0] all_out;
  assign all_out = {stall, push, pop, wdata, int_count, int_active, pc_load, pc_next,
                    flags_load, flags_out};

  int checks = 0;
  int failures = 0;
  logic [15:0] stk[$];
  logic [15:0] pushed[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs from the first cycle after acceptance until the cycle after pc_load.
  task automatic run_seq(input bit is_int, input int exp_lat, input logic [31:0] exp_pc,
                         input bit exp_fl, input logic [2:0] exp_flags, input bit drop_cmd,
                         input int irq_cyc);
    int lat;
    lat = 0;
    pushed.delete();
    for (int cyc = 1; cyc <= 10; cyc++) begin
      int_req = (cyc == irq_cyc);
      mem_rdata = (pop && stk.size() > 0) ? stk[$] : 16'h0000;
      #1;
      chk("stall_busy", 64'(stall), 64'd1);
      chk("push_pop_excl", 64'(push & pop), 64'd0);
      if (!push) chk("wdata_zero", 64'(wdata), 64'd0);
      chk("int_active", 64'(int_active), 64'(is_int && cyc <= 3));
      chk("int_count", 64'(int_count), (is_int && cyc <= 3) ? 64'(cyc) : 64'd0);
      if (push) begin
        stk.push_back(wdata);
        pushed.push_back(wdata);
      end
      if (pop && stk.size() > 0) void'(stk.pop_back());
      if (pc_load) begin
        lat = cyc;
        chk("pc_next", 64'(pc_next), 64'(exp_pc));
        chk("flags_load", 64'(flags_load), 64'(exp_fl));
        chk("flags_out", 64'(flags_out), exp_fl ? 64'(exp_flags) : 64'd0);
        if (drop_cmd) cmd_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (lat != 0) break;
    end
    int_req = 1'b0;
    chk("latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, 64'({stall, push, pop, pc_load}), 64'd0);
  endtask

  task automatic accept(input string tag);
    #1;
    chk(tag, 64'(stall), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_call_pushes(input logic [31:0] pc);
    chk("call_push_n", 64'(pushed.size()), 64'd2);
    if (pushed.size() == 2) begin
      chk("call_push_hi", 64'(pushed[0]), 64'(pc[31:16]));
      chk("call_push_lo", 64'(pushed[1]), 64'(pc[15:0]));
    end
  endtask

  task automatic chk_int_pushes(input logic [31:0] pc, input logic [2:0] fl);
    chk("int_push_n", 64'(pushed.size()), 64'd3);
    if (pushed.size() == 3) begin
      chk("int_push_hi", 64'(pushed[0]), 64'(pc[31:16]));
      chk("int_push_lo", 64'(pushed[1]), 64'(pc[15:0]));
      chk("int_push_fl", 64'(pushed[2]), 64'(fl));
    end
  endtask

  task automatic do_call(input logic [31:0] pc, input logic [31:0] tgt);
    chk_idle("idle_before_call");
    cur_pc = pc;
    cmd_target = tgt;
    flags_in = 3'($urandom);
    cmd_op = CMD_CALL;
    cmd_valid = 1'b1;
    accept("call_accept_stall");
    run_seq(1'b0, 3, tgt, 1'b0, 3'b000, 1'b1, 0);
    chk_call_pushes(pc);
  endtask

  task automatic do_int(input logic [31:0] pc, input logic [2:0] fl);
    chk_idle("idle_before_int");
    cur_pc = pc;
    flags_in = fl;
    int_req = 1'b1;
    accept("int_accept_stall");
    run_seq(1'b1, 4, IntVec, 1'b0, 3'b000, 1'b1, 0);
    chk_int_pushes(pc, fl);
  endtask

  task automatic do_ret(input int irq_cyc);
    logic [31:0] exp_pc;
    exp_pc = {stk[$-1], stk[$]};
    chk_idle("idle_before_ret");
    cmd_op = CMD_RET;
    cmd_valid = 1'b1;
    accept("ret_accept_stall");
    run_seq(1'b0, 3, exp_pc, 1'b0, 3'b000, 1'b1, irq_cyc);
    chk("ret_no_push", 64'(pushed.size()), 64'd0);
  endtask

  task automatic do_rti();
    logic [31:0] exp_pc;
    logic [15:0] top;
    top = stk[$];
    exp_pc = {stk[$-2], stk[$-1]};
    chk_idle("idle_before_rti");
    cmd_op = CMD_RTI;
    cmd_valid = 1'b1;
    accept("rti_accept_stall");
    run_seq(1'b0, 4, exp_pc, 1'b1, top[2:0], 1'b1, 0);
    chk("rti_no_push", 64'(pushed.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [31:0] pc_a;
    // Reset state.
    #2;
    chk("reset_outputs", 64'(all_out), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_after_reset", 64'(all_out), 64'd0);

    // Directed: CALL, RET, interrupt, RTI.
    do_call(32'h0001_0020, 32'h0000_0400);
    do_ret(0);
    do_int(32'h0000_0100, 3'b101);
    do_rti();

    // cmd_op NONE with cmd_valid is ignored.
    cmd_valid = 1'b1;
    cmd_op = CMD_NONE;
    #1;
    chk("none_no_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    chk("none_stays_idle", 64'(all_out), 64'd0);
    cmd_valid = 1'b0;

    // Interrupt and CALL in the same IDLE cycle: interrupt first, CALL right after.
    pc_a = 32'h1234_5678;
    cur_pc = pc_a;
    flags_in = 3'b011;
    cmd_target = 32'h0000_0800;
    cmd_op = CMD_CALL;
    cmd_valid = 1'b1;
    int_req = 1'b1;
    accept("prio_accept_stall");
    run_seq(1'b1, 4, IntVec, 1'b0, 3'b000, 1'b0, 0);
    chk_int_pushes(pc_a, 3'b011);
    accept("held_call_accept");
    run_seq(1'b0, 3, 32'h0000_0800, 1'b0, 3'b000, 1'b1, 0);
    chk_call_pushes(pc_a);

    // Interrupt raised during RET_LO waits until RET completes.
    do_ret(1);
    cur_pc = 32'h0000_4444;
    flags_in = 3'b110;
    accept("pending_int_accept");
    run_seq(1'b1, 4, IntVec, 1'b0, 3'b000, 1'b1, 0);
    chk_int_pushes(32'h0000_4444, 3'b110);

    // Reset in INT_LO abandons the sequence.
    cur_pc = 32'hAAAA_5555;
    flags_in = 3'b001;
    int_req = 1'b1;
    accept("rst_int_accept");
    int_req = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_int_lo", 64'({int_count, push}), 64'({2'b10, 1'b1}));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 64'(all_out), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stk.delete();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_quiet", 64'(all_out), 64'd0);
    end

    // Randomized op mix against the stack model.
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 4);
      if (r == 2 && stk.size() < 2) r = 0;
      if (r == 3 && stk.size() < 3) r = 1;
      case (r)
        0: do_call($urandom, $urandom);
        1: do_int($urandom, 3'($urandom));
        2: do_ret(0);
        3: do_rti();
        default: begin
          cmd_valid = 1'b1;
          cmd_op = CMD_NONE;
          #1;
          chk("rand_none_no_stall", 64'(stall), 64'd0);
          @(posedge clk);
          #1;
          cmd_valid = 1'b0;
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
